mest_pro_sequencer: RTL and testbench

Top-level control sequencer for the MESTPro core. It owns the instruction-cycle state machine and drives the one-hot stage strobes (idle/fetch/exec) consumed by the fetch stage and the execute datapath. It also provides a multi-cycle execute handshake, an execute watchdog, single-step debug and halt control. It sits between the system start/debug controls and the fetch/decode/execute datapath.

---
 rtl/mest_pro_sequencer.sv | 150 +++++++++++++++
 tb/tb_mest_pro_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mest_pro_sequencer.sv
// MESTPro instruction-cycle sequencer: stage strobes, multi-cycle
// execute handshake, watchdog, single-step and halt control.
module mest_pro_sequencer #(
  parameter int OP_CODE_SIZE = 4,
  parameter logic [OP_CODE_SIZE-1:0] HALT_OPCODE = 4'hF,
  parameter int MAX_EXEC_CYCLES = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    i_reset_n,
  input  logic                    i_start,
  input  logic                    i_halt_req,
  input  logic                    i_step_mode,
  input  logic                    i_step,
  input  logic [OP_CODE_SIZE-1:0] i_opcode,
  input  logic                    i_exec_done,
  output logic                    o_idle_state,
  output logic                    o_fetch_state,
  output logic                    o_exec_state,
  output logic                    o_exec_busy,
  output logic                    o_paused,
  output logic                    o_halted,
  output logic                    o_timeout,
  output logic [CNT_WIDTH-1:0]    o_instr_count
);

  localparam int EW = $clog2(MAX_EXEC_CYCLES);
  localparam logic [EW-1:0] EXEC_LAST = EW'(MAX_EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_PAUSE,
    ST_HALTED
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [EW-1:0] exec_cnt;
  logic          halt_pending;
  logic          halt_now;
  logic          retire;
  logic          wd_fire;

  // a request landing on the boundary cycle itself still counts
  assign halt_now = halt_pending | i_halt_req;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    wd_fire  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        if (i_opcode == HALT_OPCODE) begin
          state_nx = ST_HALTED;
        end else begin
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (i_exec_done) begin
          retire = 1'b1;
          if (halt_now) begin
            state_nx = ST_HALTED;
          end else if (i_step_mode) begin
            state_nx = ST_PAUSE;
          end else begin
            state_nx = ST_FETCH;
          end
        end else if (exec_cnt == EXEC_LAST) begin
          wd_fire  = 1'b1;
          state_nx = ST_HALTED;
        end
      end
      ST_PAUSE: begin
        if (halt_now) begin
          state_nx = ST_HALTED;
        end else if (i_step || !i_step_mode) begin
          state_nx = ST_FETCH;
        end
      end
      ST_HALTED: begin
        if (i_start) state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_idle_state  = (state == ST_IDLE);
    o_fetch_state = (state == ST_FETCH);
    o_exec_busy   = (state == ST_EXEC);
    o_exec_state  = (state == ST_EXEC) && (exec_cnt == '0);
    o_paused      = (state == ST_PAUSE);
    o_halted      = (state == ST_HALTED);
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      exec_cnt      <= '0;
      halt_pending  <= 1'b0;
      o_timeout     <= 1'b0;
      o_instr_count <= '0;
    end else begin
      if (state == ST_EXEC && state_nx == ST_EXEC) begin
        exec_cnt <= exec_cnt + 1'b1;
      end else begin
        exec_cnt <= '0;
      end

      if (state_nx == ST_HALTED) begin
        halt_pending <= 1'b0;
      end else if (i_halt_req && state != ST_IDLE
                   && state != ST_HALTED) begin
        halt_pending <= 1'b1;
      end

      if (wd_fire) begin
        o_timeout <= 1'b1;
      end else if (state == ST_HALTED && i_start) begin
        o_timeout <= 1'b0;
      end

      if (state == ST_IDLE && i_start) begin
        o_instr_count <= '0;
      end else if (retire) begin
        o_instr_count <= o_instr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mest_pro_sequencer.sv
// Bench for mest_pro_sequencer: reference model compared every
// cycle plus directed scenarios with literal expectations.
module tb_mest_pro_sequencer;

  localparam int CW   = 4;
  localparam int MAXC = 16;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_start;
  logic          i_halt_req;
  logic          i_step_mode;
  logic          i_step;
  logic [3:0]    i_opcode;
  logic          i_exec_done;
  logic          o_idle_state;
  logic          o_fetch_state;
  logic          o_exec_state;
  logic          o_exec_busy;
  logic          o_paused;
  logic          o_halted;
  logic          o_timeout;
  logic [CW-1:0] o_instr_count;

  always #5 clk = ~clk;

  mest_pro_sequencer #(
    .OP_CODE_SIZE(4),
    .HALT_OPCODE(4'hF),
    .MAX_EXEC_CYCLES(MAXC),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .i_reset_n(i_reset_n),
    .i_start(i_start),
    .i_halt_req(i_halt_req),
    .i_step_mode(i_step_mode),
    .i_step(i_step),
    .i_opcode(i_opcode),
    .i_exec_done(i_exec_done),
    .o_idle_state(o_idle_state),
    .o_fetch_state(o_fetch_state),
    .o_exec_state(o_exec_state),
    .o_exec_busy(o_exec_busy),
    .o_paused(o_paused),
    .o_halted(o_halted),
    .o_timeout(o_timeout),
    .o_instr_count(o_instr_count)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // reference model, advanced once per rising edge
  typedef enum int {M_IDLE, M_FETCH, M_DEC, M_EXEC, M_PAUSE, M_HALT} ms_t;
  ms_t m_st;
  ms_t m_nx;
  int  m_age;
  bit  m_pend;
  bit  m_to;
  int  m_cnt;
  bit  m_hb;

  always @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_st = M_IDLE;
      m_age = 0;
      m_pend = 0;
      m_to = 0;
      m_cnt = 0;
    end else begin
      m_nx = m_st;
      m_hb = m_pend || i_halt_req;
      case (m_st)
        M_IDLE: if (i_start) begin m_nx = M_FETCH; m_cnt = 0; end
        M_FETCH: m_nx = M_DEC;
        M_DEC: begin
          m_nx = (i_opcode == 4'hF) ? M_HALT : M_EXEC;
          m_age = 0;
        end
        M_EXEC: begin
          if (i_exec_done) begin
            m_cnt++;
            m_nx = m_hb ? M_HALT : (i_step_mode ? M_PAUSE : M_FETCH);
          end else if (m_age == MAXC - 1) begin
            m_nx = M_HALT;
            m_to = 1;
          end else begin
            m_age++;
          end
        end
        M_PAUSE: begin
          if (m_hb) m_nx = M_HALT;
          else if (i_step || !i_step_mode) m_nx = M_FETCH;
        end
        M_HALT: if (i_start) begin m_nx = M_IDLE; m_to = 0; end
        default: m_nx = M_IDLE;
      endcase
      if (m_nx == M_HALT) m_pend = 0;
      else if (i_halt_req && m_st != M_IDLE && m_st != M_HALT) m_pend = 1;
      m_st = m_nx;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_idle", o_idle_state, m_st == M_IDLE);
      chk("m_fetch", o_fetch_state, m_st == M_FETCH);
      chk("m_exec_state", o_exec_state, m_st == M_EXEC && m_age == 0);
      chk("m_busy", o_exec_busy, m_st == M_EXEC);
      chk("m_paused", o_paused, m_st == M_PAUSE);
      chk("m_halted", o_halted, m_st == M_HALT);
      chk("m_timeout", o_timeout, m_to);
      chk("m_count", o_instr_count, m_cnt % (1 << CW));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // entered at a FETCH negedge; done_at<0 means never complete
  task automatic run_instr(input int done_at, input int hmode,
                           output int busy_n, output int es_n);
    bit ended;
    busy_n = 0;
    es_n = 0;
    ended = 0;
    cyc();
    if (hmode == 1) i_halt_req = 1'b1;
    for (int i = 0; i < MAXC + 2; i++) begin
      cyc();
      i_halt_req = 1'b0;
      if (o_exec_busy) busy_n++;
      if (o_exec_state) es_n++;
      i_exec_done = (i == done_at);
      i_halt_req = (hmode == 2 && i == done_at);
      if (!o_exec_busy) begin
        ended = 1;
        break;
      end
    end
    i_exec_done = 1'b0;
    i_halt_req = 1'b0;
    if (!ended) chk("instr_bound", 0, 1);
  endtask

  task automatic restart();
    i_start = 1'b1;
    cyc();
    chk("restart_idle", o_idle_state, 1);
    chk("restart_to_clr", o_timeout, 0);
    cyc();
    chk("restart_fetch", o_fetch_state, 1);
    chk("restart_cnt0", o_instr_count, 0);
    i_start = 1'b0;
  endtask

  int b;
  int e;
  int es_sum;

  initial begin
    i_reset_n = 1'b0;
    i_start = 1'b0;
    i_halt_req = 1'b0;
    i_step_mode = 1'b0;
    i_step = 1'b0;
    i_opcode = 4'h1;
    i_exec_done = 1'b0;
    repeat (2) cyc();
    chk("rst_idle", o_idle_state, 1);
    chk("rst_fetch", o_fetch_state, 0);
    chk("rst_busy", o_exec_busy, 0);
    chk("rst_halted", o_halted, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_count", o_instr_count, 0);
    i_reset_n = 1'b1;
    chk_en = 1'b1;

    // four single-cycle instructions, halt requested in the last DECODE
    i_start = 1'b1;
    cyc();
    chk("start_latency", o_fetch_state, 1);
    i_start = 1'b0;
    es_sum = 0;
    for (int k = 0; k < 4; k++) begin
      run_instr(0, (k == 3) ? 1 : 0, b, e);
      es_sum += e;
      chk("single_busy", b, 1);
    end
    chk("exec_pulses", es_sum, 4);
    chk("halt_dec_halted", o_halted, 1);
    chk("halt_dec_count", o_instr_count, 4);

    // halt opcode at decode
    restart();
    run_instr(0, 0, b, e);
    i_opcode = 4'hF;
    cyc();
    cyc();
    chk("hop_halted", o_halted, 1);
    chk("hop_count", o_instr_count, 1);
    i_opcode = 4'h1;

    // delayed done, then watchdog
    restart();
    run_instr(5, 0, b, e);
    chk("dly_busy", b, 6);
    chk("dly_es", e, 1);
    chk("dly_count", o_instr_count, 1);
    run_instr(-1, 0, b, e);
    chk("wd_busy", b, MAXC);
    chk("wd_halted", o_halted, 1);
    chk("wd_timeout", o_timeout, 1);
    chk("wd_count", o_instr_count, 1);

    // single step
    restart();
    i_step_mode = 1'b1;
    run_instr(0, 0, b, e);
    chk("step_paused", o_paused, 1);
    repeat (3) cyc();
    chk("step_hold", o_paused, 1);
    i_step = 1'b1;
    cyc();
    i_step = 1'b0;
    chk("step_fetch", o_fetch_state, 1);
    run_instr(0, 0, b, e);
    chk("step_count2", o_instr_count, 2);
    i_step = 1'b1;
    cyc();
    run_instr(0, 0, b, e);
    chk("step_lvl_pause", o_paused, 1);
    chk("step_count3", o_instr_count, 3);
    cyc();
    chk("step_lvl_fetch", o_fetch_state, 1);
    i_step = 1'b0;
    run_instr(0, 0, b, e);
    i_step_mode = 1'b0;
    cyc();
    chk("resume_fetch", o_fetch_state, 1);
    run_instr(0, 0, b, e);
    chk("free_fetch", o_fetch_state, 1);
    chk("free_count", o_instr_count, 5);
    i_step_mode = 1'b1;
    run_instr(0, 0, b, e);
    i_halt_req = 1'b1;
    cyc();
    i_halt_req = 1'b0;
    chk("pause_halt", o_halted, 1);
    i_step_mode = 1'b0;

    // halt coincident with done
    restart();
    run_instr(2, 2, b, e);
    chk("coinc_halted", o_halted, 1);
    chk("coinc_count", o_instr_count, 1);

    // halt request in IDLE is dropped
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    i_halt_req = 1'b1;
    cyc();
    cyc();
    chk("idle_hold", o_idle_state, 1);
    i_halt_req = 1'b0;
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    run_instr(0, 0, b, e);
    chk("idle_halt_ign", o_fetch_state, 1);

    // counter wrap at 2^CW
    for (int k = 0; k < 15; k++) run_instr(0, 0, b, e);
    chk("wrap_count", o_instr_count, 0);

    // async reset mid-EXEC
    cyc();
    cyc();
    cyc();
    chk("pre_rst_busy", o_exec_busy, 1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("arst_idle", o_idle_state, 1);
    chk("arst_busy", o_exec_busy, 0);
    chk("arst_count", o_instr_count, 0);
    chk("arst_fetch", o_fetch_state, 0);
    cyc();
    i_reset_n = 1'b1;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
